pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Parametrised, elastic successor to the combinational opcode decoder. Decodes the 6-bit instruction opcode into the processor control bundle and carries it through a configurable number of registered stages with valid/ready handshakes. Adds flush, illegal-opcode flagging and a structural-hazard hold for multi-cycle mul/div/mod. Sits between fetch and the execute-stage control consumers.

## Interface
- `STAGES`, 2: number of registered pipeline stages, legal 1..4
- `MUL_CYCLES`, 3: issue occupancy of mul, legal 1..16
- `DIV_CYCLES`, 8: issue occupancy of div/mod, legal 1..16
- `CTRL_W`, 23: control bundle width, fixed by package
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: opcode valid
- `in_ready` out 1: unit accepts opcode this cycle
- `opcode` in 6: {op[4:0], I}, with op = opcode[5:1] and I = opcode[0]
- `flush` in 1: kill all in-flight entries and any hold
- `out_valid` out 1: last stage holds a valid bundle
- `out_ready` in 1: consumer accepts bundle
- `out_ctrl` out CTRL_W: decoded bundle; bit order isSt0 isLd1 isBeq2 isBgt3 isRet4 isImmediate5 isWb6 isUbranch7 isCall8 isAdd9 isSub10 isCmp11 isMul12 isDiv13 isMod14 isLsl15 isLsr16 isAsr17 isOr18 isAnd19 isNot20 isMov21 isIllegal22
- `out_busy` out 1: FSM in HOLD

## Operation
- **Op map:** add 00000, sub 00001, mul 00010, div 00011, mod 00100, cmp 00101, and 00110, or 00111, not 01000, mov 01001, lsl 01010, lsr 01011, asr 01100, ld 01110, st 01111, beq 10000, bgt 10001, b 10010, call 10011, ret 10100.
- **Any other op:** isIllegal=1 and all other bits 0, including isImmediate.
- **Decode rules:**
  - isImmediate = I.
  - ld and st also set isAdd.
  - isWb = add|sub|mul|div|mod|and|or|not|mov|ld|lsl|lsr|asr|call.
  - isUbranch = b|call|ret.
  - cmp, st, beq, bgt and ret never write back.
- **Accept:** an opcode is accepted when in_valid & in_ready.
- **Pipeline:** each stage has a valid bit and advances when the next stage is empty or advancing. The last stage advances on out_ready.
  - Data in a stage is cleared to 0 when it is invalidated.
  - out_ctrl is 0 whenever out_valid is 0.
- **in_ready** = !flush & state==RUN & (stage 0 empty | stage 0 advancing).
- **FSM states:**
  - RUN: accepting opcodes.
  - HOLD: in_ready=0; down-counter `cnt` (4 bits) is active.
- **Entering HOLD:** accepting mul with MUL_CYCLES>1 loads cnt=MUL_CYCLES-1 and enters HOLD. Div/mod does the same with DIV_CYCLES. A value of 1 means no HOLD.
- **In HOLD:** cnt decrements each cycle and returns to RUN in the cycle cnt reaches 1. The pipeline keeps draining during HOLD.
- **Flush:** clears all stage valids and data and sets state=RUN, cnt=0. It takes priority over a simultaneous accept, which is dropped, and over out_ready. The bundle presented in the flush cycle counts as not consumed.

## Timing
- **Reset values:** out_valid=0, out_ctrl=0, out_busy=0, state=RUN, cnt=0. in_ready=1 in the first cycle after rst deasserts.
- **Latency:** a bundle accepted at edge N is presented at out_valid after STAGES edges, provided no backpressure.
- **Throughput:** one bundle per cycle for non-multicycle ops.
- **Multicycle ops:** a mul blocks input for MUL_CYCLES-1 cycles after its accept cycle, and div/mod for DIV_CYCLES-1 cycles. The next accept is therefore MUL_CYCLES (or DIV_CYCLES) cycles after the mul/div/mod accept.
- **Backpressure:** with out_ready=0, all stages fill, then in_ready drops. Nothing is lost or duplicated, and out_ctrl stays stable while out_valid & !out_ready.
- **rst mid-HOLD or mid-stall:** the full reset state applies on the next edge.

## Structure
- **Package `ctrl_pkg`:** op localparams, bit-index localparams for the bundle, CTRL_W=23, and the FSM state enum {RUN, HOLD}.
- **Sub-module `ctrl_decode`:** purely combinational opcode→bundle decoder. The top instantiates it once at the input and a generate loop of STAGES valid/data registers.

## Test plan
- **Basic decode:** rst, then ld-imm 0x1D with out_ready=1 → out_valid after 2 cycles, out_ctrl=0x000262. Add 0x00 → 0x000240. Call 0x26 → 0x0001C0. Ret 0x28 → 0x000090.
- **Illegal opcode:** 0x3F → out_ctrl=0x400000, isWb=0.
- **Mul hold:** mul 0x04 then add, in_valid held high → in_ready low for 2 cycles, out_busy=1 for those cycles, add accepted 3 cycles after mul. Mul out_ctrl=0x001040.
- **Backpressure:** out_ready=0 while feeding 4 adds → 2 accepted (STAGES=2), in_ready=0 afterwards. Releasing out_ready outputs all entries in order with no duplicates.
- **Flush during HOLD:** div 0x06, flush 2 cycles later → out_valid=0, out_busy=0 the next cycle, in_ready=1.
- **Flush vs accept:** flush and in_valid in the same cycle → opcode not accepted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode map, control-bundle
// bit positions and the issue FSM state type.
package ctrl_pkg;

  localparam int CTRL_W = 23;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam int IS_ST        = 0;
  localparam int IS_LD        = 1;
  localparam int IS_BEQ       = 2;
  localparam int IS_BGT       = 3;
  localparam int IS_RET       = 4;
  localparam int IS_IMMEDIATE = 5;
  localparam int IS_WB        = 6;
  localparam int IS_UBRANCH   = 7;
  localparam int IS_CALL      = 8;
  localparam int IS_ADD       = 9;
  localparam int IS_SUB       = 10;
  localparam int IS_CMP       = 11;
  localparam int IS_MUL       = 12;
  localparam int IS_DIV       = 13;
  localparam int IS_MOD       = 14;
  localparam int IS_LSL       = 15;
  localparam int IS_LSR       = 16;
  localparam int IS_ASR       = 17;
  localparam int IS_OR        = 18;
  localparam int IS_AND       = 19;
  localparam int IS_NOT       = 20;
  localparam int IS_MOV       = 21;
  localparam int IS_ILLEGAL   = 22;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} fsmStateT;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control bundle decoder. Unknown ops raise only
// isIllegal so downstream consumers never see a half-decoded bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] ctrl
);

  logic [4:0]        op;
  logic              legal;
  logic [CTRL_W-1:0] base;

  assign op = opcode[5:1];

  always_comb begin
    base  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  begin base[IS_ADD] = 1'b1; base[IS_WB] = 1'b1; end
      OP_SUB:  begin base[IS_SUB] = 1'b1; base[IS_WB] = 1'b1; end
      OP_MUL:  begin base[IS_MUL] = 1'b1; base[IS_WB] = 1'b1; end
      OP_DIV:  begin base[IS_DIV] = 1'b1; base[IS_WB] = 1'b1; end
      OP_MOD:  begin base[IS_MOD] = 1'b1; base[IS_WB] = 1'b1; end
      OP_CMP:  base[IS_CMP] = 1'b1;
      OP_AND:  begin base[IS_AND] = 1'b1; base[IS_WB] = 1'b1; end
      OP_OR:   begin base[IS_OR]  = 1'b1; base[IS_WB] = 1'b1; end
      OP_NOT:  begin base[IS_NOT] = 1'b1; base[IS_WB] = 1'b1; end
      OP_MOV:  begin base[IS_MOV] = 1'b1; base[IS_WB] = 1'b1; end
      OP_LSL:  begin base[IS_LSL] = 1'b1; base[IS_WB] = 1'b1; end
      OP_LSR:  begin base[IS_LSR] = 1'b1; base[IS_WB] = 1'b1; end
      OP_ASR:  begin base[IS_ASR] = 1'b1; base[IS_WB] = 1'b1; end
      // Memory ops reuse the adder for address generation.
      OP_LD:   begin base[IS_LD] = 1'b1; base[IS_ADD] = 1'b1; base[IS_WB] = 1'b1; end
      OP_ST:   begin base[IS_ST] = 1'b1; base[IS_ADD] = 1'b1; end
      OP_BEQ:  base[IS_BEQ] = 1'b1;
      OP_BGT:  base[IS_BGT] = 1'b1;
      OP_B:    base[IS_UBRANCH] = 1'b1;
      OP_CALL: begin base[IS_CALL] = 1'b1; base[IS_UBRANCH] = 1'b1; base[IS_WB] = 1'b1; end
      OP_RET:  begin base[IS_RET] = 1'b1; base[IS_UBRANCH] = 1'b1; end
      default: legal = 1'b0;
    endcase
    ctrl = base;
    if (legal) ctrl[IS_IMMEDIATE] = opcode[0];
    else       ctrl[IS_ILLEGAL]   = 1'b1;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Elastic decode pipeline: decodes at the input, carries the bundle through
// STAGES valid/ready registers and holds issue while mul/div/mod occupy the unit.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [5:0]                  opcode,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ctrl_pkg::CTRL_W-1:0] out_ctrl,
  output logic                        out_busy
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  logic [CTRL_W-1:0] decCtrl;
  logic              accept;
  fsmStateT          stateReg;
  logic [3:0]        cntReg;

  logic [STAGES-1:0] validReg;
  logic [CTRL_W-1:0] dataReg [STAGES];
  logic [STAGES:0]   canTake;
  logic [STAGES-1:0] stageInValid;
  logic [CTRL_W-1:0] stageInData [STAGES];

  ctrl_decode uDecode (
    .opcode (opcode),
    .ctrl   (decCtrl)
  );

  // canTake[i]: stage i can load this cycle (empty, or its occupant moves on).
  assign canTake[STAGES] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gStage
      assign canTake[gi] = !validReg[gi] | canTake[gi+1];
      if (gi == 0) begin : gHead
        assign stageInValid[gi] = accept;
        assign stageInData[gi]  = decCtrl;
      end else begin : gBody
        assign stageInValid[gi] = validReg[gi-1] & canTake[gi];
        assign stageInData[gi]  = dataReg[gi-1];
      end
    end
  endgenerate

  assign in_ready  = !flush && (stateReg == RUN) && canTake[0];
  assign accept    = in_valid && in_ready;
  assign out_valid = validReg[STAGES-1];
  assign out_ctrl  = dataReg[STAGES-1];
  assign out_busy  = (stateReg == HOLD);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      validReg <= '0;
      for (int i = 0; i < STAGES; i++) dataReg[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (canTake[i]) begin
          validReg[i] <= stageInValid[i];
          dataReg[i]  <= stageInValid[i] ? stageInData[i] : '0;
        end
      end
    end
  end

  // Issue FSM: cnt counts the remaining blocked cycles after a multicycle accept.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stateReg <= RUN;
      cntReg   <= '0;
    end else begin
      case (stateReg)
        RUN: begin
          if (accept && decCtrl[IS_MUL] && (MUL_CYCLES > 1)) begin
            stateReg <= HOLD;
            cntReg   <= MUL_LOAD;
          end else if (accept && (decCtrl[IS_DIV] || decCtrl[IS_MOD]) && (DIV_CYCLES > 1)) begin
            stateReg <= HOLD;
            cntReg   <= DIV_LOAD;
          end
        end
        HOLD: begin
          if (cntReg <= 4'd1) begin
            stateReg <= RUN;
            cntReg   <= '0;
          end else begin
            cntReg <= cntReg - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Randomized + directed bench for pipelined_control_unit against a queue-based
// reference model of in-flight bundles and remaining issue-block cycles.
module tb_pipelined_control_unit;

  localparam int STAGES     = 2;
  localparam int MUL_CYCLES = 3;
  localparam int DIV_CYCLES = 8;
  localparam int CW         = 23;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready, out_busy;
  logic [5:0]    opcode;
  logic [CW-1:0] out_ctrl;

  always #5 clk = ~clk;

  pipelined_control_unit #(
    .STAGES     (STAGES),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_busy  (out_busy)
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    int            pos;
  } entryT;

  entryT         modelQ[$];
  logic [CW-1:0] gotQ[$];
  int            holdLeft = 0;
  int            errors = 0;
  int            checks = 0;
  int            stepNo = 0;
  int            acceptCount = 0;
  int            lastAcceptStep = -1;
  int            firstValidStep = -1;
  logic          sReady, sValid, sBusy;
  logic [CW-1:0] sCtrl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, stepNo, got, exp);
    end
  endtask

  // Reference decode written directly from the op map and bundle rules.
  function automatic logic [CW-1:0] refDecode(input logic [5:0] opc);
    int            op;
    logic [CW-1:0] b;
    op = int'(opc[5:1]);
    b  = '0;
    if (!((op <= 12) || (op >= 14 && op <= 20))) begin
      b[22] = 1'b1;
      return b;
    end
    b[0]  = (op == 15);
    b[1]  = (op == 14);
    b[2]  = (op == 16);
    b[3]  = (op == 17);
    b[4]  = (op == 20);
    b[5]  = opc[0];
    b[6]  = (op inside {0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 14, 19});
    b[7]  = (op inside {18, 19, 20});
    b[8]  = (op == 19);
    b[9]  = (op inside {0, 14, 15});
    b[10] = (op == 1);
    b[11] = (op == 5);
    b[12] = (op == 2);
    b[13] = (op == 3);
    b[14] = (op == 4);
    b[15] = (op == 10);
    b[16] = (op == 11);
    b[17] = (op == 12);
    b[18] = (op == 7);
    b[19] = (op == 6);
    b[20] = (op == 8);
    b[21] = (op == 9);
    return b;
  endfunction

  // One cycle: drive inputs, compare DUT with model, then advance the model at the edge.
  task automatic step(input logic iv, input logic [5:0] op, input logic ordy,
                      input logic fl, input logic rs);
    logic          expReady, expValid, expBusy, acc;
    logic [CW-1:0] expCtrl, c;
    int            limit, np;
    entryT         e;
    @(negedge clk);
    in_valid = iv; opcode = op; out_ready = ordy; flush = fl; rst = rs;
    #1;
    sReady = in_ready; sValid = out_valid; sBusy = out_busy; sCtrl = out_ctrl;
    expValid = (modelQ.size() > 0) && (modelQ[0].pos == STAGES - 1);
    expCtrl  = expValid ? modelQ[0].ctrl : '0;
    expBusy  = (holdLeft > 0);
    expReady = !fl && (holdLeft == 0) && ((modelQ.size() < STAGES) || ordy);
    chk("in_ready", 32'(sReady), 32'(expReady));
    chk("out_valid", 32'(sValid), 32'(expValid));
    chk("out_busy", 32'(sBusy), 32'(expBusy));
    chk("out_ctrl", 32'(sCtrl), 32'(expCtrl));
    if (sValid && firstValidStep < 0) firstValidStep = stepNo;
    if (sValid && ordy && !fl && !rs) begin
      gotQ.push_back(sCtrl);
      $display("step %0d consumed ctrl=%06h", stepNo, sCtrl);
    end
    if (iv && sReady && !rs) begin
      acceptCount++;
      lastAcceptStep = stepNo;
    end
    acc = iv && expReady && !rs;
    @(posedge clk);
    if (rs || fl) begin
      modelQ.delete();
      holdLeft = 0;
    end else begin
      if (expValid && ordy) void'(modelQ.pop_front());
      limit = STAGES - 1;
      for (int i = 0; i < modelQ.size(); i++) begin
        e  = modelQ[i];
        np = e.pos + 1;
        if (np > limit) np = limit;
        e.pos = np;
        modelQ[i] = e;
        limit = np - 1;
      end
      c = refDecode(op);
      if (holdLeft > 0) holdLeft--;
      else if (acc && c[12] && MUL_CYCLES > 1) holdLeft = MUL_CYCLES - 1;
      else if (acc && (c[13] || c[14]) && DIV_CYCLES > 1) holdLeft = DIV_CYCLES - 1;
      if (acc) begin
        e.ctrl = c;
        e.pos  = 0;
        modelQ.push_back(e);
      end
    end
    stepNo++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int legalOps[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14, 15, 16, 17, 18, 19, 20};
    int s0, mulStep, busyCount;
    logic [5:0] rop;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);

    // Basic decode and latency
    gotQ.delete(); firstValidStep = -1;
    s0 = stepNo;
    step(1'b1, 6'h1D, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h26, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h28, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("latency", 32'(firstValidStep - s0), 32'(STAGES));
    chk("basic_count", 32'(gotQ.size()), 32'd4);
    chk("ld_imm", 32'(gotQ[0]), 32'h000262);
    chk("add", 32'(gotQ[1]), 32'h000240);
    chk("call", 32'(gotQ[2]), 32'h0001C0);
    chk("ret", 32'(gotQ[3]), 32'h000090);

    // Illegal opcode
    gotQ.delete();
    step(1'b1, 6'h3F, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("illegal", 32'(gotQ[0]), 32'h400000);

    // Mul hold with in_valid held high
    gotQ.delete(); busyCount = 0;
    step(1'b1, 6'h04, 1'b1, 1'b0, 1'b0);
    mulStep = stepNo - 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 6'h00, 1'b1, 1'b0, 1'b0);
      if (sBusy) busyCount++;
      if (lastAcceptStep != mulStep) break;
    end
    idle(3);
    chk("mul_gap", 32'(lastAcceptStep - mulStep), 32'(MUL_CYCLES));
    chk("mul_busy", 32'(busyCount), 32'(MUL_CYCLES - 1));
    chk("mul_ctrl", 32'(gotQ[0]), 32'h001040);
    chk("add_after_mul", 32'(gotQ[1]), 32'h000240);

    // Backpressure: STAGES entries fit, then input stalls; release drains in order
    acceptCount = 0;
    step(1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    chk("bp_accepts", 32'(acceptCount), 32'(STAGES));
    chk("bp_ready_low", 32'(sReady), 32'd0);
    chk("bp_stable", 32'(sCtrl), 32'h000240);
    gotQ.delete();
    idle(4);
    chk("bp_count", 32'(gotQ.size()), 32'd2);
    chk("bp_first", 32'(gotQ[0]), 32'h000240);
    chk("bp_second", 32'(gotQ[1]), 32'h000260);

    // Flush two cycles into a div hold
    step(1'b1, 6'h06, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("flush_valid", 32'(sValid), 32'd0);
    chk("flush_busy", 32'(sBusy), 32'd0);
    chk("flush_ready", 32'(sReady), 32'd1);

    // Flush beats a simultaneous accept
    gotQ.delete(); acceptCount = 0;
    step(1'b1, 6'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_acc_ready", 32'(sReady), 32'd0);
    idle(3);
    chk("flush_acc_dropped", 32'(gotQ.size()), 32'd0);

    // Reset in the middle of a hold
    step(1'b1, 6'h08, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("rst_busy", 32'(sBusy), 32'd0);
    chk("rst_ready", 32'(sReady), 32'd1);
    chk("rst_valid", 32'(sValid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) < 8)
        rop = {5'(legalOps[$urandom_range(19)]), 1'($urandom_range(1))};
      else
        rop = 6'($urandom_range(63));
      step(1'($urandom_range(9) < 7), rop, 1'($urandom_range(9) < 7),
           1'($urandom_range(39) == 0), 1'($urandom_range(499) == 0));
    end
    idle(STAGES + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
